dm_load_controller: RTL and testbench
=====================================

DM_LOAD_CONTROLLER -- requirements
Module: dm_load_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 32, byte-address width.
- DM_LAT, 1, data-memory read latency in cycles; legal range 1..4.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  load request present.
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
- i_req_addr  in  ADDR_W  byte address.
- i_req_unit  in  2  access size: B=2'b00, HW=2'b01, W=2'b10, DW=2'b11.
- i_req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- o_dm_rd_en  out  1  one-cycle read strobe to the data memory.
- o_dm_addr  out  ADDR_W-3  64-bit line index.
- i_dm_rd_data  in  64  line data, valid exactly DM_LAT cycles after the o_dm_rd_en cycle.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  64  aligned, extended load result.
- o_miss_aligned_error  out  1  response carries a misalignment fault.
- o_staller  out  1  pipeline stall request.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-004 The output o_req_ready SHALL equal (state==IDLE) && !rst.
REQ-005 The output o_staller SHALL equal (state!=IDLE).
REQ-006 A request SHALL be accepted when i_req_valid && o_req_ready; at acceptance the block SHALL latch off=i_req_addr[2:0], i_req_unit and i_req_unsigned.
REQ-007 Misalignment SHALL be defined as any of: HW with off==7; W with off in {5,6,7}; DW with off!=0; B never misaligned.
REQ-008 On an aligned acceptance, o_dm_rd_en SHALL be high in the acceptance cycle only, o_dm_addr SHALL equal i_req_addr[ADDR_W-1:3], the latency counter SHALL load DM_LAT, and the next state SHALL be WAIT.
REQ-009 On a misaligned acceptance, o_dm_rd_en SHALL stay low, the response register SHALL load data=0 with error=1, and the next state SHALL be RESP.
REQ-010 In WAIT the counter SHALL decrement by 1 per cycle.
REQ-011 In the WAIT cycle where the counter equals 1, the block SHALL sample i_dm_rd_data, register the extracted result with error=0, and move to RESP.
REQ-012 Extraction SHALL be:
- B: line[off*8 +: 8].
- HW: line[off*8 +: 16].
- W: line[off*8 +: 32].
- DW: line[63:0].
- The B, HW and W results SHALL be sign-extended from their MSB to 64 bits when i_req_unsigned==0, else zero-extended.
- i_req_unsigned SHALL be ignored for DW.
REQ-013 The output o_rsp_valid SHALL be 1 exactly while in RESP, giving acceptance-to-o_rsp_valid latency of DM_LAT+1 cycles (aligned) and 1 cycle (misaligned).
REQ-014 In RESP, o_rsp_data and o_miss_aligned_error SHALL hold stable until i_rsp_ready==1; on that cycle the next state SHALL be IDLE.
REQ-015 The outputs o_rsp_data and o_miss_aligned_error SHALL read 0 whenever o_rsp_valid==0.
REQ-016 The inputs i_req_valid, i_req_addr, i_req_unit and i_req_unsigned SHALL be ignored while not IDLE; there SHALL be no queuing and at most one outstanding request.
REQ-017 The inputs i_dm_rd_data and i_rsp_ready SHALL be ignored outside the sample cycle of REQ-011 and outside RESP, respectively.
REQ-018 The earliest new acceptance SHALL be the cycle after the RESP handshake.

Reset
REQ-019 When rst is high at a clock edge the block SHALL clear state to IDLE, the counter to 0, the response register to 0 and the latched request fields to 0.
REQ-020 While rst is high, o_req_ready, o_dm_rd_en, o_rsp_valid, o_miss_aligned_error and o_staller SHALL be 0, and o_rsp_data and o_dm_addr SHALL be 0.
REQ-021 On reset mid-operation (WAIT or RESP), the in-flight request SHALL be dropped, no response SHALL be produced, and later-arriving i_dm_rd_data SHALL be ignored.

Verification
REQ-022 The bench SHALL cover, with DM_LAT=1 and line 0x8877_6655_4433_2211 unless stated:
- LB, addr 0x1007, signed -> o_dm_addr=0x200, o_rsp_valid 2 cycles after acceptance, data 0xFFFF_FFFF_FFFF_FF88; same request unsigned -> 0x0000_0000_0000_0088.
- LH at offset 6, signed -> 0xFFFF_FFFF_FFFF_8877; LW at offset 4, unsigned -> 0x0000_0000_8877_6655; LW at offset 4, signed -> 0xFFFF_FFFF_8877_6655.
- LW, addr 0x1005 -> o_dm_rd_en never high, o_rsp_valid 1 cycle after acceptance, error=1, data=0; HW at offset 7 and DW at offset 4 give the same error behaviour.
- i_rsp_ready held low 3 cycles in RESP, with a new i_req_valid applied -> data stable, o_req_ready=0, o_staller=1, new request not accepted until the cycle after the handshake.
- rst pulsed in the cycle after o_dm_rd_en -> next cycle IDLE, o_rsp_valid stays 0 despite line data arriving, o_req_ready=1 once rst falls.
- DM_LAT=3, DW, addr 0x2000 -> line sampled 3 cycles after the o_dm_rd_en cycle, o_rsp_valid 4 cycles after acceptance, data 0x8877_6655_4433_2211, error=0.

Source files
------------

// File: rtl/dm_load_controller.sv
`default_nettype none
// ============================================================================
// Module      : dm_load_controller
// Description : Single-outstanding load controller. Accepts one load request,
//               detects misalignment, issues a read to a 64-bit-line data
//               memory with fixed latency DM_LAT, extracts and extends the
//               requested byte/half/word/double and presents it with a
//               valid/ready handshake. Stalls the pipeline while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_load_controller #(
    parameter int ADDR_W = 32,
    parameter int DM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_unit,
    input  logic              i_req_unsigned,
    output logic              o_dm_rd_en,
    output logic [ADDR_W-4:0] o_dm_addr,
    input  logic [63:0]       i_dm_rd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [63:0]       o_rsp_data,
    output logic              o_miss_aligned_error,
    output logic              o_staller
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] U_B  = 2'b00;
    localparam logic [1:0] U_HW = 2'b01;
    localparam logic [1:0] U_W  = 2'b10;
    localparam logic [1:0] U_DW = 2'b11;

    localparam logic [2:0] LAT_INIT = 3'(DM_LAT);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [2:0]  off_q,   off_d;
    logic [1:0]  unit_q,  unit_d;
    logic        uns_q,   uns_d;
    logic [63:0] data_q,  data_d;
    logic        err_q,   err_d;

    logic        w_accept;
    logic        w_misaligned;
    logic [63:0] w_shifted;
    logic [63:0] w_extracted;

    assign o_req_ready = (state_q == S_IDLE) && !rst;
    assign w_accept    = i_req_valid && o_req_ready;

    // Misalignment: access would cross the 64-bit line boundary
    always_comb begin
        w_misaligned = 1'b0;
        case (i_req_unit)
            U_HW:    w_misaligned = (i_req_addr[2:0] == 3'd7);
            U_W:     w_misaligned = (i_req_addr[2:0] >= 3'd5);
            U_DW:    w_misaligned = (i_req_addr[2:0] != 3'd0);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Align the line on the latched byte offset, then extend per access size
    always_comb begin
        w_shifted   = i_dm_rd_data >> {off_q, 3'b000};
        w_extracted = i_dm_rd_data;
        case (unit_q)
            U_B:     w_extracted = {{56{!uns_q && w_shifted[7]}},  w_shifted[7:0]};
            U_HW:    w_extracted = {{48{!uns_q && w_shifted[15]}}, w_shifted[15:0]};
            U_W:     w_extracted = {{32{!uns_q && w_shifted[31]}}, w_shifted[31:0]};
            default: w_extracted = i_dm_rd_data;
        endcase
    end

    // Next-state logic for FSM, latency counter, latched request and response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        unit_d  = unit_q;
        uns_d   = uns_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    off_d  = i_req_addr[2:0];
                    unit_d = i_req_unit;
                    uns_d  = i_req_unsigned;
                    if (w_misaligned) begin
                        data_d  = 64'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = LAT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    data_d  = w_extracted;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            off_q   <= 3'd0;
            unit_q  <= 2'd0;
            uns_q   <= 1'b0;
            data_q  <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            unit_q  <= unit_d;
            uns_q   <= uns_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated so nothing leaks while idle or in reset
    assign o_dm_rd_en           = w_accept && !w_misaligned;
    assign o_dm_addr            = o_dm_rd_en ? i_req_addr[ADDR_W-1:3] : '0;
    assign o_rsp_valid          = (state_q == S_RESP) && !rst;
    assign o_rsp_data           = o_rsp_valid ? data_q : 64'd0;
    assign o_miss_aligned_error = o_rsp_valid && err_q;
    assign o_staller            = (state_q != S_IDLE) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_dm_load_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_load_controller
// Description : Directed self-checking bench; one instance with DM_LAT=1 and
//               one with DM_LAT=3 share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_load_controller;

    localparam logic [63:0] LINE = 64'h8877_6655_4433_2211;
    localparam logic [63:0] GARB = 64'hDEAD_BEEF_CAFE_F00D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // DM_LAT = 1 instance
    logic        req_valid = 0, req_uns = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0;
    logic [1:0]  req_unit = 0;
    logic [63:0] dm_data = 0;
    logic        req_ready, dm_rd_en, rsp_valid, err, staller;
    logic [28:0] dm_addr;
    logic [63:0] rsp_data;

    dm_load_controller #(.ADDR_W(32), .DM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_unit(req_unit), .i_req_unsigned(req_uns),
        .o_dm_rd_en(dm_rd_en), .o_dm_addr(dm_addr), .i_dm_rd_data(dm_data),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_miss_aligned_error(err), .o_staller(staller)
    );

    // DM_LAT = 3 instance
    logic        b_req_valid = 0, b_req_uns = 0, b_rsp_ready = 0;
    logic [31:0] b_req_addr = 0;
    logic [1:0]  b_req_unit = 0;
    logic [63:0] b_dm_data = 0;
    logic        b_req_ready, b_dm_rd_en, b_rsp_valid, b_err, b_staller;
    logic [28:0] b_dm_addr;
    logic [63:0] b_rsp_data;

    dm_load_controller #(.ADDR_W(32), .DM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_addr(b_req_addr), .i_req_unit(b_req_unit), .i_req_unsigned(b_req_uns),
        .o_dm_rd_en(b_dm_rd_en), .o_dm_addr(b_dm_addr), .i_dm_rd_data(b_dm_data),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_data(b_rsp_data),
        .o_miss_aligned_error(b_err), .o_staller(b_staller)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1; req_valid = 1; req_addr = 32'h1000; req_unit = 2'b00;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", req_ready); else passed++;
        checks++; if (dm_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", dm_rd_en); else passed++;
        checks++; if (dm_addr !== 29'd0) $display("FAIL reset_dm_addr got=%h exp=0", dm_addr); else passed++;
        checks++; if ({rsp_valid, err, staller} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {rsp_valid, err, staller}); else passed++;
        checks++; if (rsp_data !== 64'd0) $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); else passed++;
        @(negedge clk);
        rst = 0; req_valid = 0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", req_ready); else passed++;
        checks++; if (b_req_ready !== 1'b1) $display("FAIL post_reset_ready3 got=%b exp=1", b_req_ready); else passed++;
        checks++; if (staller !== 1'b0) $display("FAIL post_reset_staller got=%b exp=0", staller); else passed++;
    endtask

    // One complete load on the DM_LAT=1 instance with line data present only
    // in the cycle right after the read strobe.
    task automatic run_load(input string nm, input logic [31:0] addr, input logic [1:0] unit,
                            input logic uns, input logic [63:0] exp_d, input logic exp_e);
        int  lat;
        int  exp_lat;
        logic seen_rd;
        logic leak;
        exp_lat = exp_e ? 1 : 2;
        @(negedge clk);
        req_valid = 1; req_addr = addr; req_unit = unit; req_uns = uns; dm_data = GARB;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL %s_accept_ready got=%b exp=1", nm, req_ready); else passed++;
        checks++; if (dm_rd_en !== !exp_e) $display("FAIL %s_rd_en got=%b exp=%b", nm, dm_rd_en, !exp_e); else passed++;
        if (!exp_e) begin
            checks++; if (dm_addr !== addr[31:3]) $display("FAIL %s_dm_addr got=%h exp=%h", nm, dm_addr, addr[31:3]); else passed++;
        end
        lat = 0; seen_rd = 0; leak = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req_valid = 0; req_addr = 32'hFFFF_FFFF; req_unit = 2'b11;
            dm_data = (k == 1) ? LINE : GARB;
            #1;
            if (dm_rd_en) seen_rd = 1;
            if (!rsp_valid && (rsp_data !== 64'd0 || err !== 1'b0)) leak = 1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== exp_lat) $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, exp_lat); else passed++;
        checks++; if (seen_rd !== 1'b0 || leak !== 1'b0) $display("FAIL %s_quiet got=rd%b/leak%b exp=0/0", nm, seen_rd, leak); else passed++;
        checks++; if (rsp_data !== exp_d) $display("FAIL %s_data got=%h exp=%h", nm, rsp_data, exp_d); else passed++;
        checks++; if (err !== exp_e) $display("FAIL %s_err got=%b exp=%b", nm, err, exp_e); else passed++;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        #1;
        checks++; if ({req_ready, rsp_valid, staller} !== 3'b100) $display("FAIL %s_back_idle got=%b exp=100", nm, {req_ready, rsp_valid, staller}); else passed++;
        checks++; if (rsp_data !== 64'd0) $display("FAIL %s_idle_data got=%h exp=0", nm, rsp_data); else passed++;
    endtask

    task automatic test_aligned_loads();
        run_load("lb_s",  32'h1007, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        run_load("lb_u",  32'h1007, 2'b00, 1'b1, 64'h0000_0000_0000_0088, 1'b0);
        run_load("lh_s6", 32'h1006, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_8877, 1'b0);
        run_load("lw_u4", 32'h1004, 2'b10, 1'b1, 64'h0000_0000_8877_6655, 1'b0);
        run_load("lw_s4", 32'h1004, 2'b10, 1'b0, 64'hFFFF_FFFF_8877_6655, 1'b0);
        run_load("lb_s2", 32'h1002, 2'b00, 1'b0, 64'h0000_0000_0000_0033, 1'b0);
        run_load("ld_0",  32'h1000, 2'b11, 1'b1, LINE, 1'b0);
    endtask

    task automatic test_misaligned();
        run_load("lw_mis5", 32'h1005, 2'b10, 1'b0, 64'd0, 1'b1);
        run_load("lh_mis7", 32'h1007, 2'b01, 1'b0, 64'd0, 1'b1);
        run_load("ld_mis4", 32'h1004, 2'b11, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 1; req_addr = 32'h1004; req_unit = 2'b10; req_uns = 1; dm_data = GARB;
        @(negedge clk);
        req_valid = 1; req_addr = 32'h1007; req_unit = 2'b00; req_uns = 0; dm_data = LINE;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL bp_wait_ready got=%b exp=0", req_ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dm_data = GARB;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'h0000_0000_8877_6655 || req_ready !== 1'b0 ||
                staller !== 1'b1 || dm_rd_en !== 1'b0)
                $display("FAIL bp_hold%0d got=v%b d=%h rdy%b st%b en%b exp=v1 d=0000000088776655 rdy0 st1 en0",
                         k, rsp_valid, rsp_data, req_ready, staller, dm_rd_en);
            else passed++;
        end
        @(negedge clk);
        rsp_ready = 1;
        #1;
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) $display("FAIL bp_handshake got=rdy%b v%b exp=rdy0 v1", req_ready, rsp_valid); else passed++;
        @(negedge clk);
        rsp_ready = 0;
        #1;
        checks++; if (req_ready !== 1'b1 || dm_rd_en !== 1'b1 || dm_addr !== 29'h200)
            $display("FAIL bp_new_accept got=rdy%b en%b a=%h exp=rdy1 en1 a=200", req_ready, dm_rd_en, dm_addr);
        else passed++;
        @(negedge clk);
        req_valid = 0; dm_data = LINE;
        @(negedge clk);
        dm_data = GARB;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hFFFF_FFFF_FFFF_FF88)
            $display("FAIL bp_second_rsp got=v%b d=%h exp=v1 d=ffffffffffffff88", rsp_valid, rsp_data);
        else passed++;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid_flight();
        logic seen;
        @(negedge clk);
        req_valid = 1; req_addr = 32'h1000; req_unit = 2'b00; req_uns = 0; dm_data = GARB;
        #1;
        checks++; if (dm_rd_en !== 1'b1) $display("FAIL rmf_rd_en got=%b exp=1", dm_rd_en); else passed++;
        @(negedge clk);
        req_valid = 0; rst = 1; dm_data = LINE;
        #1;
        checks++; if (req_ready !== 1'b0 || staller !== 1'b0) $display("FAIL rmf_during got=rdy%b st%b exp=0/0", req_ready, staller); else passed++;
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (req_ready !== 1'b1 || staller !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL rmf_idle got=rdy%b st%b v%b exp=1/0/0", req_ready, staller, rsp_valid);
        else passed++;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) seen = 1;
        end
        dm_data = GARB;
        checks++; if (seen !== 1'b0) $display("FAIL rmf_no_rsp got=%b exp=0", seen); else passed++;
    endtask

    task automatic test_latency3();
        int lat;
        int samp;
        @(negedge clk);
        b_req_valid = 1; b_req_addr = 32'h2000; b_req_unit = 2'b11; b_req_uns = 0; b_dm_data = GARB;
        #1;
        checks++; if (b_dm_rd_en !== 1'b1 || b_dm_addr !== 29'h400) $display("FAIL lat3_issue got=en%b a=%h exp=en1 a=400", b_dm_rd_en, b_dm_addr); else passed++;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            b_req_valid = 0;
            b_dm_data = (k == 3) ? LINE : GARB;
            #1;
            if (b_rsp_valid) begin
                lat = k;
                break;
            end
        end
        samp = lat;
        checks++; if (samp !== 4) $display("FAIL lat3_latency got=%0d exp=4", samp); else passed++;
        checks++; if (b_rsp_data !== LINE || b_err !== 1'b0) $display("FAIL lat3_data got=%h e%b exp=%h e0", b_rsp_data, b_err, LINE); else passed++;
        b_rsp_ready = 1;
        @(negedge clk);
        b_rsp_ready = 0;
        #1;
        checks++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) $display("FAIL lat3_idle got=rdy%b v%b exp=1/0", b_req_ready, b_rsp_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_aligned_loads();
        test_misaligned();
        test_backpressure();
        test_reset_mid_flight();
        test_latency3();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
